path_terminal_capture: RTL and testbench

Run controller and terminal-price collector that sits behind the `Path_pipe` Heston path engine. It launches a run with a one-cycle enable pulse and waits out the pipeline fill. It then de-interleaves the per-cycle `Price` stream across `LANES` interleaved paths and `STEPS+1` time points. For each path it captures only the terminal price into an output FIFO with a valid/ready handshake, replacing bench-side sampling for multi-path Monte-Carlo runs.

---
 rtl/path_pkg.sv | 32 +++
 rtl/ptc_fifo.sv | 45 ++++
 rtl/path_terminal_capture.sv | 154 +++++++++++++++
 tb/tb_path_terminal_capture.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared types and helpers for the path-engine terminal capture block.
// Holds the FSM state enum and the FIFO entry layout.
package path_pkg;

  localparam int FP_W    = 32;
  localparam int LANE_FW = 8;
  localparam int GRP_FW  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    FILL,
    RUN,
    FIN
  } ptc_state_t;

  typedef struct packed {
    logic [FP_W-1:0]    price;
    logic [LANE_FW-1:0] lane;
    logic [GRP_FW-1:0]  group;
  } ptc_entry_t;

endpackage

// File: rtl/ptc_fifo.sv
// First-word-fall-through FIFO for captured terminal prices.
// Callers only push when space exists (or a pop frees it this edge).
module ptc_fifo
  import path_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/path_terminal_capture.sv
// Run controller for Path_pipe: launches a run, walks the interleaved
// price stream and queues each path's terminal price.
module path_terminal_capture
  import path_pkg::*;
#(
  parameter int W          = 32,
  parameter int LANES      = 4,
  parameter int STEPS      = 365,
  parameter int START_LAT  = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int GW         = 16,
  localparam int LW = (LANES > 1) ? clog2(LANES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [GW-1:0] path_groups,
  output logic          pipe_en,
  input  logic [W-1:0]  price_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_price,
  output logic [LW-1:0] out_lane,
  output logic [GW-1:0] out_group,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int SW = (STEPS > 0) ? clog2(STEPS + 1) : 1;
  localparam int FW = clog2(START_LAT + 1) + 1;
  localparam int EW = $bits(ptc_entry_t);

  ptc_state_t    state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [SW-1:0] step_q, step_d;
  logic [GW-1:0] group_q, group_d;
  logic [GW-1:0] ngrp_q, ngrp_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d;

  logic       push, push_ok, pop;
  logic       full, empty;
  logic       term, lane_end, last;
  ptc_entry_t wr_e, hd_e;

  assign term     = (step_q == SW'(STEPS));
  assign lane_end = (lane_q == LW'(LANES - 1));
  assign last     = term && lane_end &&
                    (group_q == ngrp_q - GW'(1));

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    step_d  = step_q;
    group_d = group_q;
    ngrp_d  = ngrp_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ngrp_d  = path_groups;
          ovf_d   = 1'b0;
          lane_d  = '0;
          step_d  = '0;
          group_d = '0;
          fill_d  = '0;
          state_d = (path_groups == '0) ? FIN : LAUNCH;
        end
      end
      LAUNCH: begin
        fill_d  = '0;
        state_d = (START_LAT > 1) ? FILL : RUN;
      end
      FILL: begin
        if (fill_q == FW'(START_LAT - 2)) state_d = RUN;
        else fill_d = fill_q + FW'(1);
      end
      RUN: begin
        push = term;
        if (lane_end) begin
          lane_d = '0;
          if (term) begin
            step_d  = '0;
            group_d = group_q + GW'(1);
          end else begin
            step_d = step_q + SW'(1);
          end
        end else begin
          lane_d = lane_q + LW'(1);
        end
        if (last) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A pop on the same edge frees the slot for a full-FIFO push.
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      step_q  <= '0;
      group_q <= '0;
      ngrp_q  <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      step_q  <= step_d;
      group_q <= group_d;
      ngrp_q  <= ngrp_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pop     = out_valid && out_ready;
  assign push_ok = push && (!full || pop);

  assign wr_e.price = FP_W'(price_in);
  assign wr_e.lane  = LANE_FW'(lane_q);
  assign wr_e.group = GRP_FW'(group_q);

  ptc_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ok),
    .pop  (pop),
    .din  (wr_e),
    .full (full),
    .empty(empty),
    .head (hd_e)
  );

  assign out_valid = !empty;
  assign out_price = empty ? '0 : W'(hd_e.price);
  assign out_lane  = empty ? '0 : LW'(hd_e.lane);
  assign out_group = empty ? '0 : GW'(hd_e.group);
  assign pipe_en   = (state_q == LAUNCH);
  assign busy      = (state_q == LAUNCH) || (state_q == FILL) ||
                     (state_q == RUN);
  assign done      = (state_q == FIN);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_path_terminal_capture.sv
// Scoreboard bench for path_terminal_capture with a small run shape.
// price_in carries the edge number so captured prices locate samples.
module tb_path_terminal_capture;

  localparam int W          = 32;
  localparam int LANES      = 4;
  localparam int STEPS      = 3;
  localparam int START_LAT  = 7;
  localparam int FIFO_DEPTH = 8;
  localparam int GW         = 16;
  localparam int N          = LANES * (STEPS + 1);

  logic          clk, rst, start, pipe_en;
  logic          out_valid, out_ready, busy, done, overflow;
  logic [GW-1:0] path_groups, out_group;
  logic [W-1:0]  price_in, out_price;
  logic [1:0]    out_lane;

  typedef struct {
    logic [31:0] price;
    logic [1:0]  lane;
    logic [15:0] group;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   E;
  int   n_cmp;
  int   n_err;

  path_terminal_capture #(
    .W(W), .LANES(LANES), .STEPS(STEPS), .START_LAT(START_LAT),
    .FIFO_DEPTH(FIFO_DEPTH), .GW(GW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .path_groups(path_groups),
    .pipe_en(pipe_en), .price_in(price_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_price(out_price), .out_lane(out_lane),
    .out_group(out_group), .busy(busy), .done(done),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Value sampled at edge k is k.
  assign price_in = 32'(cyc + 1);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int g, input int keep);
    exp_t e;
    start = 1'b1;
    path_groups = GW'(g);
    E = cyc + 1;
    tick;
    start = 1'b0;
    for (int i = 0; i < keep; i++) begin
      e.group = 16'(i / LANES);
      e.lane  = 2'(i % LANES);
      e.price = 32'(E + START_LAT + 1 + (i / LANES) * N
                    + STEPS * LANES + (i % LANES));
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    path_groups = '0;
    repeat (2) tick;
    n_cmp++;
    if ({pipe_en, busy, done, overflow, out_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {pipe_en, busy, done, overflow, out_valid});
    end
    n_cmp++;
    if (out_price !== '0) begin
      n_err++;
      $display("FAIL reset_price: got %0d want 0", out_price);
    end
    n_cmp++;
    if ({out_lane, out_group} !== '0) begin
      n_err++;
      $display("FAIL reset_tag: got %0d/%0d want 0/0", out_lane, out_group);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    out_ready = 1'b1;
    while (cyc < 9) tick;
    do_start(1, 4);
    for (int k = 0; k < 30; k++) begin
      n_cmp++;
      if (pipe_en !== (cyc == 10)) begin
        n_err++;
        $display("FAIL single_pipe_en: cyc %0d got %b", cyc, pipe_en);
      end
      n_cmp++;
      if (done !== (cyc == 33)) begin
        n_err++;
        $display("FAIL single_done: cyc %0d got %b", cyc, done);
      end
      n_cmp++;
      if (busy !== (cyc >= 10 && cyc <= 32)) begin
        n_err++;
        $display("FAIL single_busy: cyc %0d got %b", cyc, busy);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL single_extra: got %0d/%0d/%0d want none",
                   out_price, out_lane, out_group);
        end else begin
          e = sb.pop_front();
          if ({out_price, out_lane, out_group} !==
              {e.price, e.lane, e.group}) begin
            n_err++;
            $display("FAIL single_entry: got %0d/%0d/%0d want %0d/%0d/%0d",
                     out_price, out_lane, out_group,
                     e.price, e.lane, e.group);
          end
        end
      end
      tick;
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_three_groups;
    exp_t e;
    int   d;
    out_ready = 1'b1;
    tick;
    do_start(3, 12);
    d = E + START_LAT + 3 * N;
    for (int k = 0; k < START_LAT + 3 * N + 6; k++) begin
      n_cmp++;
      if (done !== (cyc == d)) begin
        n_err++;
        $display("FAIL three_done: cyc %0d got %b", cyc, done);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL three_extra: got %0d/%0d/%0d want none",
                   out_price, out_lane, out_group);
        end else begin
          e = sb.pop_front();
          if ({out_price, out_lane, out_group} !==
              {e.price, e.lane, e.group}) begin
            n_err++;
            $display("FAIL three_entry: got %0d/%0d/%0d want %0d/%0d/%0d",
                     out_price, out_lane, out_group,
                     e.price, e.lane, e.group);
          end
        end
      end
      tick;
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL three_ovf: got %b want 0", overflow);
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL three_left: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   d;
    int   npop;
    out_ready = 1'b0;
    tick;
    do_start(3, 8);
    d = E + START_LAT + 3 * N;
    for (int k = 0; k < START_LAT + 3 * N + 3; k++) begin
      n_cmp++;
      if (done !== (cyc == d)) begin
        n_err++;
        $display("FAIL bp_done: cyc %0d got %b", cyc, done);
      end
      tick;
    end
    n_cmp++;
    if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ovf: got ovf=%b valid=%b want 1/1",
               overflow, out_valid);
    end
    out_ready = 1'b1;
    npop = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid && out_ready) begin
        npop++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra: got %0d/%0d/%0d want none",
                   out_price, out_lane, out_group);
        end else begin
          e = sb.pop_front();
          if ({out_price, out_lane, out_group} !==
              {e.price, e.lane, e.group}) begin
            n_err++;
            $display("FAIL bp_entry: got %0d/%0d/%0d want %0d/%0d/%0d",
                     out_price, out_lane, out_group,
                     e.price, e.lane, e.group);
          end
        end
      end
      tick;
    end
    n_cmp++;
    if (npop != 8 || sb.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d pops want 8", npop);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL bp_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_full_pop;
    exp_t e;
    int   npop;
    out_ready = 1'b0;
    tick;
    do_start(2, 8);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_ovf_clear: got %b want 0", overflow);
    end
    for (int k = 0; k < START_LAT + 2 * N + 2; k++) tick;
    n_cmp++;
    if (out_valid !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_pre: got valid=%b ovf=%b want 1/0",
               out_valid, overflow);
    end
    do_start(1, 4);
    for (int k = 0; k < START_LAT + N + 3; k++) begin
      out_ready = (cyc >= E + 19 && cyc <= E + 22);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL full_extra: got %0d/%0d/%0d want none",
                   out_price, out_lane, out_group);
        end else begin
          e = sb.pop_front();
          if ({out_price, out_lane, out_group} !==
              {e.price, e.lane, e.group}) begin
            n_err++;
            $display("FAIL full_entry: got %0d/%0d/%0d want %0d/%0d/%0d",
                     out_price, out_lane, out_group,
                     e.price, e.lane, e.group);
          end
        end
      end
      tick;
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_ovf: got %b want 0", overflow);
    end
    out_ready = 1'b1;
    npop = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid && out_ready) begin
        npop++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL full_drain_extra: got %0d/%0d/%0d want none",
                   out_price, out_lane, out_group);
        end else begin
          e = sb.pop_front();
          if ({out_price, out_lane, out_group} !==
              {e.price, e.lane, e.group}) begin
            n_err++;
            $display("FAIL full_drain: got %0d/%0d/%0d want %0d/%0d/%0d",
                     out_price, out_lane, out_group,
                     e.price, e.lane, e.group);
          end
        end
      end
      tick;
    end
    n_cmp++;
    if (npop != 8 || sb.size() != 0) begin
      n_err++;
      $display("FAIL full_occupancy: got %0d pops want 8", npop);
    end
  endtask

  task automatic test_zero_busy;
    exp_t e;
    int   d;
    int   npop;
    out_ready = 1'b1;
    tick;
    do_start(0, 0);
    n_cmp++;
    if ({done, pipe_en, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL zero_done: got done/pipe_en/busy=%b want 100",
               {done, pipe_en, busy});
    end
    tick;
    n_cmp++;
    if ({done, pipe_en, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL zero_after: got done/pipe_en/busy=%b want 000",
               {done, pipe_en, busy});
    end
    tick;
    do_start(1, 4);
    d = E + START_LAT + N;
    npop = 0;
    for (int k = 0; k < START_LAT + N + 6; k++) begin
      start = (cyc == E + 12) || (cyc == d);
      path_groups = GW'(3);
      n_cmp++;
      if (done !== (cyc == d)) begin
        n_err++;
        $display("FAIL busy_done: cyc %0d got %b", cyc, done);
      end
      n_cmp++;
      if (busy !== (cyc >= E && cyc < d)) begin
        n_err++;
        $display("FAIL busy_flag: cyc %0d got %b", cyc, busy);
      end
      if (out_valid && out_ready) begin
        npop++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL busy_extra: got %0d/%0d/%0d want none",
                   out_price, out_lane, out_group);
        end else begin
          e = sb.pop_front();
          if ({out_price, out_lane, out_group} !==
              {e.price, e.lane, e.group}) begin
            n_err++;
            $display("FAIL busy_entry: got %0d/%0d/%0d want %0d/%0d/%0d",
                     out_price, out_lane, out_group,
                     e.price, e.lane, e.group);
          end
        end
      end
      tick;
    end
    start = 1'b0;
    n_cmp++;
    if (npop != 4 || sb.size() != 0) begin
      n_err++;
      $display("FAIL busy_count: got %0d entries want 4", npop);
    end
  endtask

  task automatic test_reset_mid_run;
    out_ready = 1'b0;
    tick;
    do_start(2, 0);
    for (int k = 0; k < START_LAT + N + 2; k++) tick;
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: got valid=%b busy=%b want 1/1",
               out_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pipe_en, busy, done, overflow, out_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL rmid_ctrl: got %b want 00000",
               {pipe_en, busy, done, overflow, out_valid});
    end
    n_cmp++;
    if ({out_price, out_lane, out_group} !== '0) begin
      n_err++;
      $display("FAIL rmid_data: got %0d/%0d/%0d want 0/0/0",
               out_price, out_lane, out_group);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_single;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    start = 1'b0;
    out_ready = 1'b0;
    path_groups = '0;
    rst = 1'b1;
    test_reset;
    test_single;
    test_three_groups;
    test_backpressure;
    test_full_pop;
    test_zero_busy;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
